count_step_monitor: RTL
=======================

// Module: count_step_monitor
// PURPOSE
//  Downstream checker for the 3-bit synchronous up/down counter (sync_3bit).
//  - Samples the counter value and its mode input every clock.
//  - Verifies that each step is exactly +1 (mode=1) or -1 (mode=0), modulo 2^WIDTH.
//  - Emits one-cycle wrap pulses and keeps saturating up/down wrap tallies.
//  - Latches the first illegal step in a sticky error state.
//  - Sits beside the counter on the same clock; feeds status and debug logic.
// PARAMETERS
//  WIDTH   3  counter width being monitored
//  WRAP_W  8  width of each saturating wrap tally
// PORTS
//  in_clk        in   1        single clock; all state updates on its rising edge
//  in_rst        in   1        synchronous, active-high reset
//  in_q          in   WIDTH    counter value (counter o_q)
//  in_m          in   1        counter mode, same net that drives the counter (1=up, 0=down)
//  in_clr        in   1        synchronous clear of error, tallies and tracking
//  o_state       out  2        FSM state: 00=SYNC, 01=TRACK, 10=ERROR
//  o_tc_up       out  1        1-cycle pulse: up wrap (max -> 0) detected
//  o_tc_dn       out  1        1-cycle pulse: down wrap (0 -> max) detected
//  o_up_wraps    out  WRAP_W   saturating count of up wraps
//  o_dn_wraps    out  WRAP_W   saturating count of down wraps
//  o_err         out  1        sticky: an illegal step was seen
//  o_exp         out  WIDTH    expected value at the first error
//  o_got         out  WIDTH    observed value at the first error
// BEHAVIOUR
//  Reset: when in_rst=1 at an edge, all outputs become 0 and o_state becomes SYNC.
//    The internal prev_q and prev_m registers also become 0.
//  Registers: prev_q and prev_m hold in_q and in_m from the previous edge.
//    The counter's value at edge n is the result of the mode sampled at edge n-1.
//    So the expected value is exp = prev_m ? prev_q+1 : prev_q-1, truncated to WIDTH bits.
//  SYNC:
//    - Loads prev_q <= in_q and prev_m <= in_m.
//    - Performs no check and no wrap detection.
//    - Next state is TRACK. The first compare happens one edge later.
//  TRACK: on every edge, loads prev_q and prev_m, then:
//    - in_q == exp, prev_m=1, prev_q=2^WIDTH-1: up wrap.
//      o_tc_up=1 for one cycle; o_up_wraps += 1.
//    - in_q == exp, prev_m=0, prev_q=0: down wrap.
//      o_tc_dn=1 for one cycle; o_dn_wraps += 1.
//    - in_q != exp: next state is ERROR.
//      o_err <= 1, o_exp <= exp, o_got <= in_q.
//      No wrap pulse or tally change on that edge.
//    - A mode change between edges is legal. The new mode governs the following step.
//  ERROR:
//    - Holds o_err, o_exp and o_got; later mismatches do not overwrite them.
//    - Wrap detection and tallies are frozen; pulses stay 0.
//    - Leaves only on in_clr or in_rst.
//  Pulses: o_tc_up and o_tc_dn are registered.
//    They are high in the cycle after the edge that sampled the wrapped value.
//    They are never high together.
//  Saturation: a tally at 2^WRAP_W-1 holds; it does not roll over.
//  Clear: in_clr=1 at an edge, from any state:
//    - Next state is SYNC.
//    - o_err, o_exp, o_got, both tallies and both pulses become 0.
//  Priority: in_rst > in_clr > mismatch > wrap.
//  Mid-operation: a reset or clear during TRACK discards history. The next edge is SYNC.
//  Latency: 1 edge from the sampled input to every output.
// STRUCTURE
//  Package cnt_mon_pkg:
//    - localparams ST_SYNC, ST_TRACK, ST_ERROR.
//    - function next_exp(prev_q, prev_m).
//  Sub-module sat_counter #(W): inc, clr and in_rst inputs; saturating output.
//    Instantiated twice, once for up wraps and once for down wraps.
//  Top level holds the FSM, the prev registers, the compare logic and the error capture.
// TESTING
//  1. Reset, then drive sync_3bit with in_m=1 for 20 cycles.
//     -> o_err=0; o_tc_up pulses twice; o_up_wraps=2; o_dn_wraps=0.
//  2. Drive in_m=0 from reset for 9 cycles (0,7,6,...).
//     -> o_tc_dn pulses on the 0->7 step; o_dn_wraps=1.
//  3. Force in_q to the sequence 3,4,6.
//     -> ERROR, o_err=1, o_exp=5, o_got=6; a later 7,0 gives no wrap pulse.
//  4. Toggle in_m every 2 cycles around value 0 or 7.
//     -> no error; each pulse matches the mode in effect at the previous edge.
//  5. Assert in_clr in ERROR, then in_rst mid-TRACK.
//     -> o_state=SYNC and all outputs 0 next cycle; the first post-clear sample is not checked.
//  6. Use WRAP_W=2 with 5 up wraps.
//     -> o_up_wraps saturates at 3; o_tc_up still pulses 5 times.

Source files
------------

// File: rtl/cnt_mon_pkg.sv
// ---------------------------------------------------------------------------
// Package: cnt_mon_pkg
// Purpose: Shared definitions for the counter step monitor.
//   - state_t : monitor FSM encoding (SYNC / TRACK / ERROR).
//   - next_exp: value a well-behaved up/down counter must show one edge after
//               it was seen at prevQ with mode prevM.
//
// next_exp works on a fixed wide vector so that callers of any width up to
// MAX_W can use it. The caller truncates the result to its own width, and
// that truncation is what produces the modulo-2^WIDTH wrap.
// ---------------------------------------------------------------------------
package cnt_mon_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

    localparam int MAX_W = 16;

    // One step of an up/down counter: +1 when counting up, -1 when counting down
    function automatic logic [MAX_W-1:0] next_exp(input logic [MAX_W-1:0] prevQ,
                                                  input logic              prevM);
        return prevM ? (prevQ + MAX_W'(1)) : (prevQ - MAX_W'(1));
    endfunction

endpackage

// File: rtl/count_step_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// Module: sat_counter
// Purpose: Saturating event tally. It counts in_inc pulses and sticks at the
//          all-ones value instead of rolling over.
// Ports:
//   in_clk   in   1   clock, rising edge
//   in_rst   in   1   synchronous active-high reset (highest priority)
//   in_inc   in   1   count one event this edge
//   in_clr   in   1   synchronous clear (beats in_inc)
//   o_count  out  W   current tally
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         in_clk,
    input  logic         in_rst,
    input  logic         in_inc,
    input  logic         in_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Reset and clear both zero the tally. An increment is ignored once the
    // tally is full, so a long run of events leaves it pinned at max.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_count <= '0;
        end else if (in_clr) begin
            r_count <= '0;
        end else if (in_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/count_step_monitor.sv
// ---------------------------------------------------------------------------
// Module: count_step_monitor
// Purpose: Watches a WIDTH-bit up/down counter and its mode input. It checks
//          that every step is +1 (mode=1) or -1 (mode=0) modulo 2^WIDTH,
//          flags up/down wraps, keeps saturating wrap tallies and latches the
//          first illegal step.
// Ports:
//   in_clk      in   1       clock, rising edge
//   in_rst      in   1       synchronous active-high reset
//   in_q        in   WIDTH   observed counter value
//   in_m        in   1       counter mode (1=up, 0=down)
//   in_clr      in   1       synchronous clear of error, tallies and tracking
//   o_state     out  2       00=SYNC, 01=TRACK, 10=ERROR
//   o_tc_up     out  1       one-cycle pulse: max -> 0 wrap seen
//   o_tc_dn     out  1       one-cycle pulse: 0 -> max wrap seen
//   o_up_wraps  out  WRAP_W  saturating up-wrap tally
//   o_dn_wraps  out  WRAP_W  saturating down-wrap tally
//   o_err       out  1       sticky illegal-step flag
//   o_exp       out  WIDTH   expected value at the first error
//   o_got       out  WIDTH   observed value at the first error
// ---------------------------------------------------------------------------
module count_step_monitor
    import cnt_mon_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [WIDTH-1:0]  in_q,
    input  logic              in_m,
    input  logic              in_clr,
    output logic [1:0]        o_state,
    output logic              o_tc_up,
    output logic              o_tc_dn,
    output logic [WRAP_W-1:0] o_up_wraps,
    output logic [WRAP_W-1:0] o_dn_wraps,
    output logic              o_err,
    output logic [WIDTH-1:0]  o_exp,
    output logic [WIDTH-1:0]  o_got
);

    localparam logic [WIDTH-1:0] MAX_Q = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_prevQ;
    logic             r_prevM;
    logic             r_tcUp;
    logic             r_tcDn;
    logic             r_err;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_got;

    logic [WIDTH-1:0] w_expQ;
    logic             w_match;
    logic             w_upWrap;
    logic             w_dnWrap;

    // The value sampled now was produced by the mode sampled at the previous
    // edge, so the prediction comes from the previous value and mode. A wrap
    // counts only while tracking and only on a legal step. Reset and clear
    // priority is handled by the FSM and by the tally counters.
    assign w_expQ   = WIDTH'(next_exp(MAX_W'(r_prevQ), r_prevM));
    assign w_match  = (in_q == w_expQ);
    assign w_upWrap = (r_state == ST_TRACK) && w_match &&  r_prevM && (r_prevQ == MAX_Q);
    assign w_dnWrap = (r_state == ST_TRACK) && w_match && !r_prevM && (r_prevQ == '0);

    // Monitor FSM. SYNC takes one sample without checking it, so that the
    // first compare has a valid history. TRACK checks every step. ERROR
    // freezes the first failure until a clear or reset. The pulses are
    // registered here, so each pulse appears one cycle after the edge that
    // sampled the wrapped value.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= ST_SYNC;
            r_prevQ <= '0;
            r_prevM <= 1'b0;
            r_tcUp  <= 1'b0;
            r_tcDn  <= 1'b0;
            r_err   <= 1'b0;
            r_exp   <= '0;
            r_got   <= '0;
        end else if (in_clr) begin
            r_state <= ST_SYNC;
            r_prevQ <= '0;
            r_prevM <= 1'b0;
            r_tcUp  <= 1'b0;
            r_tcDn  <= 1'b0;
            r_err   <= 1'b0;
            r_exp   <= '0;
            r_got   <= '0;
        end else begin
            r_prevQ <= in_q;
            r_prevM <= in_m;
            r_tcUp  <= 1'b0;
            r_tcDn  <= 1'b0;
            case (r_state)
                ST_SYNC: begin
                    r_state <= ST_TRACK;
                end
                ST_TRACK: begin
                    if (!w_match) begin
                        r_state <= ST_ERROR;
                        r_err   <= 1'b1;
                        r_exp   <= w_expQ;
                        r_got   <= in_q;
                    end else begin
                        r_tcUp <= w_upWrap;
                        r_tcDn <= w_dnWrap;
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

    // Two independent saturating tallies, one per wrap direction
    sat_counter #(.W(WRAP_W)) u_upTally (
        .in_clk  (in_clk),
        .in_rst  (in_rst),
        .in_inc  (w_upWrap),
        .in_clr  (in_clr),
        .o_count (o_up_wraps)
    );

    sat_counter #(.W(WRAP_W)) u_dnTally (
        .in_clk  (in_clk),
        .in_rst  (in_rst),
        .in_inc  (w_dnWrap),
        .in_clr  (in_clr),
        .o_count (o_dn_wraps)
    );

    assign o_state = r_state;
    assign o_tc_up = r_tcUp;
    assign o_tc_dn = r_tcDn;
    assign o_err   = r_err;
    assign o_exp   = r_exp;
    assign o_got   = r_got;

endmodule
